// File: rtl/jk_updown_counter.sv
// ---------------------------------------------------------------------------
// jk_updown_counter
//   Synchronous modulo up/down counter built from JK flip-flop cells.
//   The requested next state is computed combinationally, converted to per-bit
//   J/K excitation, and the state register is updated only through the JK
//   characteristic equation Q+ = J&~Q | ~K&Q.
//   With JK_CNT_SATURATE_EN defined the count stops at its limits and tc
//   flags each enabled edge blocked at a limit; otherwise it wraps and tc
//   pulses on each wrap.
// ---------------------------------------------------------------------------
module jk_updown_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MOD   = 16
) (
   input  logic             clk,
   input  logic             reset_sync_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MOD - 1);
   // Modulus held one bit wider so MOD = 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);

   logic [WIDTH-1:0] nxt;
   logic             limit_hit;   // enabled edge at MAXV going up or 0 going down
   logic             tc_nxt;

   // Requested next state; reset is applied in the register, not here.
   always_comb begin
      nxt       = count;
      limit_hit = 1'b0;
      if (load) begin
         nxt = ({1'b0, load_val} < MOD_X) ? load_val : MAXV;
      end else if (en) begin
         if (up_dn) begin
            if (count == MAXV) begin
               limit_hit = 1'b1;
`ifdef JK_CNT_SATURATE_EN
               nxt = count;
`else
               nxt = '0;
`endif
            end else begin
               nxt = count + 1'b1;
            end
         end else begin
            if (count == '0) begin
               limit_hit = 1'b1;
`ifdef JK_CNT_SATURATE_EN
               nxt = count;
`else
               nxt = MAXV;
`endif
            end else begin
               nxt = count - 1'b1;
            end
         end
      end
   end

   // Don't-cares resolved to 0: J only sets a 0 bit, K only clears a 1 bit.
   always_comb begin
      jk_j   = nxt & ~count;
      jk_k   = ~nxt & count;
      tc_nxt = limit_hit;
   end

   always_ff @(posedge clk) begin
      if (!reset_sync_n) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= (jk_j & ~count) | (~jk_k & count);
         tc    <= tc_nxt;
      end
   end

endmodule

// File: tb/tb_jk_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_updown_counter
//   Two instances share all inputs: MOD=10 and MOD=16 (both WIDTH=4).
//   Expected count/tc are pushed to per-instance queues before each edge and
//   popped after it; jk_j/jk_k are checked combinationally before the edge.
//   Honours JK_CNT_SATURATE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_jk_updown_counter;

   typedef struct {
      logic [3:0] c;
      logic       tc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn, en, up_dn, load;
   logic [3:0] load_val;

   logic [3:0] c10, j10, k10, c16, j16, k16;
   logic       tc10, tc16;

   exp_t       q10[$];
   exp_t       q16[$];
   logic [3:0] m10 = '0;
   logic [3:0] m16 = '0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jk_updown_counter #(.WIDTH(4), .MOD(10)) dut10 (
      .clk(clk), .reset_sync_n(rstn), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .count(c10), .jk_j(j10), .jk_k(k10), .tc(tc10));

   jk_updown_counter #(.WIDTH(4), .MOD(16)) dut16 (
      .clk(clk), .reset_sync_n(rstn), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .count(c16), .jk_j(j16), .jk_k(k16), .tc(tc16));

   // Behavioural reference: requested next state and the limit condition.
   function automatic void model(input int mod, input logic [3:0] cur,
                                 output logic [3:0] nx, output logic lim);
      int v;
      v   = int'(cur);
      lim = 1'b0;
      if (load) begin
         v = (int'(load_val) < mod) ? int'(load_val) : mod - 1;
      end else if (en) begin
         if (up_dn) begin
            if (v == mod - 1) begin
               lim = 1'b1;
`ifndef JK_CNT_SATURATE_EN
               v = 0;
`endif
            end else v = v + 1;
         end else begin
            if (v == 0) begin
               lim = 1'b1;
`ifndef JK_CNT_SATURATE_EN
               v = mod - 1;
`endif
            end else v = v - 1;
         end
      end
      nx = v[3:0];
   endfunction

   // Push expectations for the coming edge, advance the models, take the edge.
   task automatic tick();
      exp_t e;
      logic [3:0] nx;
      logic lim;
      model(10, m10, nx, lim);
      e.c  = rstn ? nx  : 4'd0;
      e.tc = rstn ? lim : 1'b0;
      q10.push_back(e);
      m10 = e.c;
      model(16, m16, nx, lim);
      e.c  = rstn ? nx  : 4'd0;
      e.tc = rstn ? lim : 1'b0;
      q16.push_back(e);
      m16 = e.c;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv);
      rstn = r; en = e; up_dn = u; load = l; load_val = lv;
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
      for (int i = 0; i < 2; i++) begin
         tick();
         e = q10.pop_front();
         n_cmp++;
         if (c10 !== e.c || tc10 !== e.tc) begin
            n_err++;
            $display("FAIL reset10 edge%0d: count=%0d tc=%b expected count=%0d tc=%b", i, c10, tc10, e.c, e.tc);
         end
         e = q16.pop_front();
         n_cmp++;
         if (c16 !== e.c || tc16 !== e.tc) begin
            n_err++;
            $display("FAIL reset16 edge%0d: count=%0d tc=%b expected count=%0d tc=%b", i, c16, tc16, e.c, e.tc);
         end
      end
      // Release mid-cycle: nothing may move until the next edge.
      #2;
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      n_cmp++;
      if (c10 !== 4'd0 || tc10 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: count=%0d tc=%b expected count=0 tc=0", c10, tc10);
      end
      tick();
      e = q10.pop_front();
      void'(q16.pop_front());
      n_cmp++;
      if (c10 !== e.c || tc10 !== e.tc) begin
         n_err++;
         $display("FAIL reset_hold: count=%0d tc=%b expected count=%0d tc=%b", c10, tc10, e.c, e.tc);
      end
   endtask

   task automatic test_count_up_mod10();
      exp_t e;
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 10; i++) begin
         if (i == 9) begin
            n_cmp++;
            if (j10 !== 4'b0000 || k10 !== 4'b1001) begin
               n_err++;
               $display("FAIL jk_9to0: j=%b k=%b expected j=0000 k=1001", j10, k10);
            end
         end
         tick();
         e = q10.pop_front();
         void'(q16.pop_front());
         n_cmp++;
         if (c10 !== e.c || tc10 !== e.tc || tc10 !== (i == 9)) begin
            n_err++;
            $display("FAIL up10 step%0d: count=%0d tc=%b expected count=%0d tc=%b", i, c10, tc10, e.c, e.tc);
         end
      end
   endtask

   task automatic test_load_clamp_and_down_wrap();
      exp_t e;
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd12);
      tick();
      e = q10.pop_front();
      void'(q16.pop_front());
      n_cmp++;
      if (c10 !== 4'd9 || tc10 !== 1'b0 || c10 !== e.c) begin
         n_err++;
         $display("FAIL load_clamp: count=%0d tc=%b expected count=9 tc=0", c10, tc10);
      end
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
      tick();
      void'(q10.pop_front());
      void'(q16.pop_front());
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      tick();
      e = q10.pop_front();
      void'(q16.pop_front());
      n_cmp++;
`ifdef JK_CNT_SATURATE_EN
      if (c10 !== 4'd0 || tc10 !== 1'b1 || c10 !== e.c) begin
         n_err++;
         $display("FAIL down_limit: count=%0d tc=%b expected count=0 tc=1", c10, tc10);
      end
`else
      if (c10 !== 4'd9 || tc10 !== 1'b1 || c10 !== e.c) begin
         n_err++;
         $display("FAIL down_wrap: count=%0d tc=%b expected count=9 tc=1", c10, tc10);
      end
`endif
   endtask

   task automatic test_load_priority();
      exp_t e;
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
      tick();
      void'(q10.pop_front());
      void'(q16.pop_front());
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
      tick();
      e = q10.pop_front();
      void'(q16.pop_front());
      n_cmp++;
      if (c10 !== 4'd3 || tc10 !== 1'b0 || c10 !== e.c) begin
         n_err++;
         $display("FAIL load_wins: count=%0d tc=%b expected count=3 tc=0", c10, tc10);
      end
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      n_cmp++;
      if (j10 !== 4'b0000 || k10 !== 4'b0000) begin
         n_err++;
         $display("FAIL hold_jk: j=%b k=%b expected j=0000 k=0000", j10, k10);
      end
      tick();
      void'(q16.pop_front());
      e = q10.pop_front();
      n_cmp++;
      if (c10 !== 4'd3 || tc10 !== e.tc) begin
         n_err++;
         $display("FAIL hold_count: count=%0d tc=%b expected count=3 tc=%b", c10, tc10, e.tc);
      end
   endtask

   task automatic test_mod16_reset_on_wrap();
      exp_t e;
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
      tick();
      void'(q10.pop_front());
      void'(q16.pop_front());
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      n_cmp++;
      if (j16 !== 4'b1000 || k16 !== 4'b0111) begin
         n_err++;
         $display("FAIL jk_7to8: j=%b k=%b expected j=1000 k=0111", j16, k16);
      end
      tick();
      void'(q10.pop_front());
      e = q16.pop_front();
      n_cmp++;
      if (c16 !== 4'd8 || c16 !== e.c) begin
         n_err++;
         $display("FAIL up16_7to8: count=%0d expected 8", c16);
      end
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
      tick();
      void'(q10.pop_front());
      void'(q16.pop_front());
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      tick();
      void'(q10.pop_front());
      e = q16.pop_front();
      n_cmp++;
      if (c16 !== 4'd0 || tc16 !== 1'b0 || tc16 !== e.tc) begin
         n_err++;
         $display("FAIL reset_on_wrap: count=%0d tc=%b expected count=0 tc=0", c16, tc16);
      end
   endtask

   task automatic test_random();
      exp_t e;
      logic [3:0] nx;
      logic lim;
      for (int i = 0; i < 2000; i++) begin
         set_in(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                4'($urandom_range(0, 15)));
         if (rstn) begin
            model(10, m10, nx, lim);
            n_cmp++;
            if (j10 !== (nx & ~m10) || k10 !== (~nx & m10)) begin
               n_err++;
               $display("FAIL rnd_jk10 cyc%0d: j=%b k=%b expected j=%b k=%b", i, j10, k10, nx & ~m10, ~nx & m10);
            end
            model(16, m16, nx, lim);
            n_cmp++;
            if (j16 !== (nx & ~m16) || k16 !== (~nx & m16)) begin
               n_err++;
               $display("FAIL rnd_jk16 cyc%0d: j=%b k=%b expected j=%b k=%b", i, j16, k16, nx & ~m16, ~nx & m16);
            end
         end
         tick();
         e = q10.pop_front();
         n_cmp++;
         if (c10 !== e.c || tc10 !== e.tc) begin
            n_err++;
            $display("FAIL rnd10 cyc%0d: count=%0d tc=%b expected count=%0d tc=%b", i, c10, tc10, e.c, e.tc);
         end
         e = q16.pop_front();
         n_cmp++;
         if (c16 !== e.c || tc16 !== e.tc) begin
            n_err++;
            $display("FAIL rnd16 cyc%0d: count=%0d tc=%b expected count=%0d tc=%b", i, c16, tc16, e.c, e.tc);
         end
      end
   endtask

   initial begin
      rstn = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_count_up_mod10();
      test_load_clamp_and_down_wrap();
      test_load_priority();
      test_mod16_reset_on_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
